// File: rtl/rr_arb8_ctrl_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: requester count,
// index width and controller state encoding.
package rr_arb8_ctrl_pkg;

   localparam int unsigned NREQ  = 8;
   localparam int unsigned IDX_W = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/rr_arb8_ctrl_onehot_dec3.sv
// Combinational 3-to-8 one-hot decoder; all outputs low when en is low.
module onehot_dec3
   import rr_arb8_ctrl_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   input  logic             en,
   output logic [NREQ-1:0]  onehot
);

   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/rr_arb8_ctrl.sv
// Round-robin arbiter that shares one decoded 8-way select between 8
// requesters, with an optional hold limit that preempts a long-running owner.
module rr_arb8_ctrl
   import rr_arb8_ctrl_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req,
   output logic [NREQ-1:0]     gnt,
   output logic [IDX_W-1:0]    gnt_idx,
   output logic                gnt_valid,
   output logic                preempt
);

   localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] CNT_START = (MAX_HOLD == 0) ? '0 : CNT_W'(1);

   state_t              state, nxt_state;
   logic [IDX_W-1:0]    last, nxt_last;
   logic [CNT_W-1:0]    hold_cnt, nxt_cnt;
   logic [IDX_W-1:0]    nxt_idx;
   logic                nxt_valid;
   logic                nxt_pre;
   logic [NREQ-1:0]     gnt_d;
   logic                found;
   logic [IDX_W-1:0]    win_idx;
   logic [IDX_W-1:0]    cand;
   logic                others;

   // Rotating search from last+1; while granted, last equals the owner, so the
   // same search serves both fresh grants and handovers from the owner.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = last + IDX_W'(k);
         if (!found && req[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
      end
   end

   assign others = |(req & ~gnt);

   always_comb begin
      nxt_state = state;
      nxt_idx   = gnt_idx;
      nxt_valid = gnt_valid;
      nxt_cnt   = hold_cnt;
      nxt_last  = last;
      nxt_pre   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (found) begin
               nxt_state = ST_GRANT;
               nxt_idx   = win_idx;
               nxt_valid = 1'b1;
               nxt_cnt   = CNT_START;
               nxt_last  = win_idx;
            end
         end
         ST_GRANT: begin
            if (!req[gnt_idx]) begin
               if (found) begin
                  nxt_idx  = win_idx;
                  nxt_cnt  = CNT_START;
                  nxt_last = win_idx;
               end else begin
                  nxt_state = ST_IDLE;
                  nxt_idx   = '0;
                  nxt_valid = 1'b0;
                  nxt_cnt   = '0;
               end
            end else if (MAX_HOLD != 0 && hold_cnt == HOLD_MAX && others) begin
               nxt_idx  = win_idx;
               nxt_cnt  = CNT_START;
               nxt_last = win_idx;
               nxt_pre  = 1'b1;
            end else if (MAX_HOLD != 0 && hold_cnt != HOLD_MAX) begin
               nxt_cnt = hold_cnt + CNT_W'(1);
            end
         end
         default: begin
            nxt_state = ST_IDLE;
            nxt_idx   = '0;
            nxt_valid = 1'b0;
            nxt_cnt   = '0;
         end
      endcase
   end

   onehot_dec3 u_dec (
      .idx    (nxt_idx),
      .en     (nxt_valid),
      .onehot (gnt_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         gnt       <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
         preempt   <= 1'b0;
         hold_cnt  <= '0;
         last      <= IDX_W'(NREQ - 1);
      end else begin
         state     <= nxt_state;
         gnt       <= gnt_d;
         gnt_idx   <= nxt_idx;
         gnt_valid <= nxt_valid;
         preempt   <= nxt_pre;
         hold_cnt  <= nxt_cnt;
         last      <= nxt_last;
      end
   end

endmodule
